// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, with valid/ready on both sides.
// Optional macro SERIAL_ADDER_SUB_EN adds a Sub input that turns the operation into A-B.

module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Subtraction is A + ~B + 1, so only the loaded operand and carry change.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = Sub ? ~B : B;
  assign c_load = Sub ? 1'b1 : Cin;
`else
  assign b_load = B;
  assign c_load = Cin;
`endif

  one_bit_full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_nxt = fa_s;
    end else begin : g_wn
      assign sum_nxt = {fa_s, sum_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            a_sr     <= A;
            b_sr     <= b_load;
            carry    <= c_load;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_nxt;
          carry  <= fa_co;
          cnt    <= cnt + CW'(1);
          // Last bit: publish the completed word on the same edge it finishes.
          if (cnt == CNT_LAST) begin
            Sum       <= sum_nxt;
            Cout      <= fa_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          Sum       <= '0;
          Cout      <= 1'b0;
          a_sr      <= '0;
          b_sr      <= '0;
          sum_sr    <= '0;
          carry     <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: accepted operands push A+B+Cin (or A-B) into a queue,
// an independent monitor pops and compares on every output handshake.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         sub = 1'b0;
  logic         sub_eff;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Sum;
  logic         Cout;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  logic [W:0] exp_q[$];
  longint     acc_q[$];
  logic       ov_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
  );

  // Reference: {Cout,Sum} is the (W+1)-bit residue of A+B+Cin, or of A-B+2^W when subtracting.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    longint r;
    if (s) r = longint'(a) - longint'(b) + (longint'(1) << W);
    else   r = longint'(a) + longint'(b) + longint'(c);
    return r[W:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, Cin, sub_eff));
        acc_q.push_back(cyc + 1);
      end
      if (out_valid) begin
        check("in_ready_low_while_valid", in_ready, 0);
        if (!ov_prev) begin
          if (acc_q.size() > 0) check("latency", cyc - acc_q.pop_front(), W);
          else fail("unexpected_output");
        end
        if (exp_q.size() == 0) fail("no_expected_result");
        else if (out_ready) check("result", {Cout, Sum}, exp_q.pop_front());
        else check("stall_stable", {Cout, Sum}, exp_q[0]);
      end
    end
    ov_prev <= out_valid;
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    int n;
    A = a; B = b; Cin = c; sub = s; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) fail("accept_timeout");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) fail("drain_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    longint acc_t[3];
    logic [W-1:0] ra, rb;
    int n;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
    rst = 1'b0;

    out_ready = 1'b1;
    send(8'h5A, 8'h33, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    check("in_ready_after_handshake", in_ready, 1);
    check("sum_5a_33", {Cout, Sum}, 9'h08D);
    @(posedge clk); #1;

    send(8'hFF, 8'h01, 1'b0, 1'b0);
    drain();
    check("sum_ff_01", {Cout, Sum}, 9'h100);
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    drain();
    check("sum_ff_ff_c1", {Cout, Sum}, 9'h1FF);

    // Backpressure with a stray in_valid pulse during the stall
    out_ready = 1'b0;
    send(8'h0F, 8'h01, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!out_valid) fail("out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin A = 8'hAA; B = 8'h55; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall_sum", {Cout, Sum}, 9'h010);
    out_ready = 1'b1;
    drain();
    repeat (W + 3) @(posedge clk);
    #1;
    check("no_stray_accept", out_valid, 0);

    // Asynchronous reset in the middle of SHIFT
    send(8'hC3, 8'h3C, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_sum", Sum, 0);
    check("abort_cout", Cout, 0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'h01, 8'h01, 1'b0, 1'b0);
    drain();
    check("post_reset_sum", {Cout, Sum}, 9'h002);

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = W'($urandom); B = W'($urandom); Cin = 1'(i); sub = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 200);
      if (!in_ready) fail("b2b_accept_timeout");
      acc_t[i] = cyc + 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("b2b_spacing_1", acc_t[1] - acc_t[0], W + 2);
    check("b2b_spacing_2", acc_t[2] - acc_t[1], W + 2);
    drain();

`ifdef SERIAL_ADDER_SUB_EN
    send(8'h10, 8'h01, 1'b0, 1'b1);
    drain();
    check("sub_10_01", {Cout, Sum}, 9'h10F);
    send(8'h01, 8'h02, 1'b0, 1'b1);
    drain();
    check("sub_01_02", {Cout, Sum}, 9'h0FF);
`endif

    // Randomized operands with random consumer stalls
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
      send(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
`endif
      repeat ($urandom_range(0, W + 4)) @(posedge clk);
      #1 out_ready = 1'b1;
      drain();
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
